// File: rtl/vga_rx_decoder_if.sv
// VGA receive link bundle: sync/colour pins in, recovered pixel stream out.
// Optional frame checksum signals exist only when VGA_RX_FRAME_SUM_EN is defined.
interface vga_rx_decoder_if;
  logic        hSync;
  logic        vSync;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] pixel;
  logic        pixelValid;
  logic        frameStart;
  logic        locked;
  logic        syncError;
  logic [7:0]  errCount;
`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] frameSum;
  logic        frameSumValid;
`endif

  modport master (
`ifdef VGA_RX_FRAME_SUM_EN
    input  frameSum,
    input  frameSumValid,
`endif
    output hSync,
    output vSync,
    output VGA_R,
    output VGA_G,
    output VGA_B,
    input  x,
    input  y,
    input  pixel,
    input  pixelValid,
    input  frameStart,
    input  locked,
    input  syncError,
    input  errCount
  );

  modport slave (
`ifdef VGA_RX_FRAME_SUM_EN
    output frameSum,
    output frameSumValid,
`endif
    input  hSync,
    input  vSync,
    input  VGA_R,
    input  VGA_G,
    input  VGA_B,
    output x,
    output y,
    output pixel,
    output pixelValid,
    output frameStart,
    output locked,
    output syncError,
    output errCount
  );
endinterface

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers x/y, checks sync timing, reports lock/errors.
// Define VGA_RX_FRAME_SUM_EN to add the per-frame pixel checksum outputs.
module vga_rx_decoder #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic             clk,
  input logic             reset,
  vga_rx_decoder_if.slave bus
);

  localparam int H_TOTAL = H_FP + H_SYNC + H_BP + WIDTH;
  localparam int V_TOTAL = V_FP + V_SYNC + V_BP + HEIGHT;

  localparam logic [9:0] HT    = 10'(H_TOTAL);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_A0  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_A1  = 10'(H_SYNC + H_BP + WIDTH - 1);
  localparam logic [9:0] VT    = 10'(V_TOTAL);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_A0  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_A1  = 10'(V_SYNC + V_BP + HEIGHT - 1);
  localparam logic [3:0] LF    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    HUNT,
    SYNCING,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_n;

  logic        hs1;
  logic        vs1;
  logic        hs1_d;
  logic        vs1_d;
  logic [11:0] rgb1;

  logic        hfall;
  logic        vfall;
  logic        vpend;
  logic        vzero;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  hc_n;
  logic [9:0]  vc_n;

  logic        fvalid;
  logic [3:0]  good_cnt;

  logic        short_line;
  logic        long_line;
  logic        short_frame;
  logic        long_frame;
  logic        checking;
  logic        viol;
  logic        good;

  logic        lock_n;
  logic        pv_n;
  logic        fs_n;
  logic [9:0]  x_n;
  logic [8:0]  y_n;

  // Stage 1: register the pins, keep previous sync levels for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      hs1_d <= 1'b1;
      vs1_d <= 1'b1;
      rgb1  <= '0;
    end else begin
      hs1   <= bus.hSync;
      vs1   <= bus.vSync;
      hs1_d <= hs1;
      vs1_d <= vs1;
      rgb1  <= {bus.VGA_R, bus.VGA_G, bus.VGA_B};
    end
  end

  assign hfall = hs1_d & ~hs1;
  assign vfall = vs1_d & ~vs1;
  assign vzero = hfall & (vfall | vpend);

  // Next column/row count for the current stage-1 sample; both saturate.
  always_comb begin
    hc_n = h_cnt + 10'd1;
    if (hfall) begin
      hc_n = '0;
    end else if (h_cnt == HT) begin
      hc_n = HT;
    end
    vc_n = v_cnt;
    if (vzero) begin
      vc_n = '0;
    end else if (hfall) begin
      vc_n = (v_cnt == VT) ? VT : v_cnt + 10'd1;
    end
  end

  // Timing checks; frame checks wait until a frame was seen from its start.
  always_comb begin
    checking    = (state != HUNT);
    short_line  = hfall & (h_cnt != HT_M1);
    long_line   = ~hfall & (h_cnt == HT_M1);
    short_frame = vzero & (v_cnt != VT_M1);
    long_frame  = hfall & ~vzero & (v_cnt == VT_M1);
    viol        = checking &
                  (short_line | long_line |
                   (fvalid & (short_frame | long_frame)));
    good        = checking & fvalid & vzero &
                  (v_cnt == VT_M1) & ~viol;
  end

  // Counter registers and the pending vSync-fall marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      vpend <= 1'b0;
    end else begin
      h_cnt <= hc_n;
      v_cnt <= vc_n;
      if (hfall) begin
        vpend <= 1'b0;
      end else if (vfall) begin
        vpend <= 1'b1;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  // Lock state transitions.
  always_comb begin
    state_n = state;
    unique case (state)
      HUNT: begin
        if (vfall) state_n = SYNCING;
      end
      SYNCING: begin
        if (viol) begin
          state_n = HUNT;
        end else if (good_cnt == LF) begin
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  // Good-frame tracking; a frame only counts if checked from its first line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fvalid   <= 1'b0;
      good_cnt <= '0;
    end else if (state == HUNT) begin
      fvalid   <= vfall & vzero;
      good_cnt <= '0;
    end else if (viol) begin
      fvalid   <= 1'b0;
      good_cnt <= '0;
    end else if (vzero) begin
      fvalid <= 1'b1;
      if (good && good_cnt != LF) begin
        good_cnt <= good_cnt + 4'd1;
      end
    end
  end

  // Output decode for the current stage-1 sample.
  always_comb begin
    lock_n = (state_n == LOCKED);
    x_n    = hc_n - H_A0;
    y_n    = 9'(vc_n - V_A0);
    pv_n   = lock_n &
             (hc_n >= H_A0) & (hc_n <= H_A1) &
             (vc_n >= V_A0) & (vc_n <= V_A1);
    fs_n   = pv_n & (x_n == '0) & (y_n == '0);
  end

  // Output registers; x/y hold outside the active window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.x          <= '0;
      bus.y          <= '0;
      bus.pixel      <= '0;
      bus.pixelValid <= 1'b0;
      bus.frameStart <= 1'b0;
      bus.locked     <= 1'b0;
      bus.syncError  <= 1'b0;
      bus.errCount   <= '0;
    end else begin
      bus.pixel      <= rgb1;
      bus.pixelValid <= pv_n;
      bus.frameStart <= fs_n;
      bus.locked     <= lock_n;
      bus.syncError  <= viol;
      if (pv_n) begin
        bus.x <= x_n;
        bus.y <= y_n;
      end
      if (viol && bus.errCount != 8'hFF) begin
        bus.errCount <= bus.errCount + 8'd1;
      end
    end
  end

`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] acc;

  // Frame checksum: restart at frameStart, publish after a good locked frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc               <= '0;
      bus.frameSum      <= '0;
      bus.frameSumValid <= 1'b0;
    end else begin
      if (fs_n) begin
        acc <= {4'd0, rgb1};
      end else if (pv_n) begin
        acc <= acc + {4'd0, rgb1};
      end
      bus.frameSumValid <= good & (state == LOCKED);
      if (good && state == LOCKED) begin
        bus.frameSum <= acc;
      end
    end
  end
`endif

endmodule
